// File: rtl/disp_scan_sched.sv
// rtl/disp_scan_sched.sv - 8-digit 7-segment scan scheduler with double-buffered display word
// Optional leading-zero suppression is compiled in with DISP_LZ_SUPPRESS_EN.
module disp_scan_sched #(
  parameter int DWELL = 1024,
  parameter int BLANK = 16,
  parameter int CNT_W = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  input  logic [7:0]  digit_mask,
  output logic [7:0]  drains,
  output logic [3:0]  tetrade,
  output logic        dot,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_t           state, nxt_state;
  logic [2:0]       idx, nxt_idx;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [31:0]      active, shadow, nxt_active;
  logic [7:0]       active_dp, shadow_dp, nxt_active_dp;
  logic             pending;
  logic             wrap, accept, swap, lit;

`ifdef DISP_LZ_SUPPRESS_EN
  logic [2:0] lz_top, nxt_top;

  function automatic logic [2:0] top_nz(input logic [31:0] w);
    logic [2:0] t;
    t = 3'd0;
    for (int i = 1; i < 8; i++)
      if (w[4*i +: 4] != 4'd0) t = 3'(i);
    return t;
  endfunction
`endif

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_cnt   = cnt;
    wrap      = 1'b0;
    if (!EN) begin
      nxt_state = IDLE;
      nxt_idx   = 3'd0;
      nxt_cnt   = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_state = SHOW;
          nxt_idx   = 3'd0;
          nxt_cnt   = DWELL_LD;
        end
        SHOW: begin
          if (cnt != '0) begin
            nxt_cnt = cnt - CNT_W'(1);
          end else if (BLANK > 0) begin
            nxt_state = GAP;
            nxt_cnt   = BLANK_LD;
          end else begin
            nxt_idx = idx + 3'd1;
            nxt_cnt = DWELL_LD;
            wrap    = (idx == 3'd7);
          end
        end
        GAP: begin
          if (cnt != '0) begin
            nxt_cnt = cnt - CNT_W'(1);
          end else begin
            nxt_state = SHOW;
            nxt_idx   = idx + 3'd1;
            nxt_cnt   = DWELL_LD;
            wrap      = (idx == 3'd7);
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_idx   = 3'd0;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Swap only at frame boundaries (or while parked) so a frame never mixes two words.
  always_comb begin
    accept        = load_valid & load_ready;
    swap          = pending & ((state == IDLE) | wrap);
    nxt_active    = swap ? shadow : active;
    nxt_active_dp = swap ? shadow_dp : active_dp;
`ifdef DISP_LZ_SUPPRESS_EN
    nxt_top = swap ? top_nz(shadow) : lz_top;
    lit     = digit_mask[nxt_idx] & (nxt_idx <= nxt_top);
`else
    lit     = digit_mask[nxt_idx];
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= '0;
      active     <= '0;
      active_dp  <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      frame_done <= 1'b0;
      drains     <= '0;
      tetrade    <= '0;
      dot        <= 1'b0;
`ifdef DISP_LZ_SUPPRESS_EN
      lz_top     <= 3'd0;
`endif
    end else begin
      state      <= nxt_state;
      idx        <= nxt_idx;
      cnt        <= nxt_cnt;
      active     <= nxt_active;
      active_dp  <= nxt_active_dp;
      if (accept) begin
        shadow    <= load_data;
        shadow_dp <= load_dp;
      end
      pending    <= accept | (pending & ~swap);
      load_ready <= accept ? 1'b0 : ~pending;
      frame_done <= wrap;
      drains     <= ((nxt_state == SHOW) && lit) ? (8'd1 << nxt_idx) : 8'd0;
      if (nxt_state == SHOW) begin
        tetrade <= nxt_active[{nxt_idx, 2'b00} +: 4];
        dot     <= nxt_active_dp[nxt_idx];
      end
`ifdef DISP_LZ_SUPPRESS_EN
      lz_top     <= nxt_top;
`endif
    end
  end

endmodule

// File: tb/tb_disp_scan_sched.sv
// tb/tb_disp_scan_sched.sv - directed bench for disp_scan_sched
// dut_a: DWELL=4 BLANK=2 (48-cycle frame); dut_b: DWELL=4 BLANK=0 (32-cycle frame).
module tb_disp_scan_sched;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN, en_b;
  logic        load_valid;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic [7:0]  mask_a, mask_b;
  logic        ready_a, ready_b;
  logic [7:0]  drains_a, drains_b;
  logic [3:0]  tetrade_a, tetrade_b;
  logic        dot_a, dot_b;
  logic        fdone_a, fdone_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  disp_scan_sched #(.DWELL(4), .BLANK(2), .CNT_W(8)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .load_valid(load_valid), .load_ready(ready_a),
    .load_data(load_data), .load_dp(load_dp), .digit_mask(mask_a), .drains(drains_a),
    .tetrade(tetrade_a), .dot(dot_a), .frame_done(fdone_a)
  );

  disp_scan_sched #(.DWELL(4), .BLANK(0), .CNT_W(8)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .EN(en_b), .load_valid(load_valid), .load_ready(ready_b),
    .load_data(load_data), .load_dp(load_dp), .digit_mask(mask_b), .drains(drains_b),
    .tetrade(tetrade_b), .dot(dot_b), .frame_done(fdone_b)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    step();
    while (fdone_a !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total_cnt++;
    if (fdone_a !== 1'b1) $display("FAIL wait_frame: frame_done=%b required 1 within 200 cycles", fdone_a);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; EN = 1'b0; en_b = 1'b0; load_valid = 1'b0;
    load_data = '0; load_dp = '0; mask_a = 8'hFF; mask_b = 8'hFF;
    step(); step();
    total_cnt++;
    if ({drains_a, tetrade_a, dot_a, fdone_a, ready_a} !== {8'h00, 4'h0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_a: got %h required %h", {drains_a, tetrade_a, dot_a, fdone_a, ready_a},
               {8'h00, 4'h0, 1'b0, 1'b0, 1'b1});
    else pass_cnt++;
    total_cnt++;
    if ({drains_b, fdone_b, ready_b} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL reset_b: got %h required %h", {drains_b, fdone_b, ready_b}, {8'h00, 1'b0, 1'b1});
    else pass_cnt++;
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_load_idle();
    logic [2:0] exp_rdy;
    exp_rdy = 3'b100;
    load_data = 32'h7654_3210; load_dp = 8'hA5; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (ready_a !== exp_rdy[i]) $display("FAIL load_idle c%0d: ready=%b required %b", i, ready_a, exp_rdy[i]);
      else pass_cnt++;
      if (i < 2) step();
    end
  endtask

  task automatic test_scan();
    logic [7:0] dp_v;
    logic [7:0] exp_dr;
    logic [3:0] exp_t;
    logic       exp_fd;
    int slot, pos;
    dp_v = 8'hA5;
    EN = 1'b1;
    for (int k = 0; k <= 96; k++) begin
      step();
      slot   = (k / 6) % 8;
      pos    = k % 6;
      exp_dr = (pos < 4) ? (8'd1 << slot) : 8'd0;
      exp_t  = 4'(slot);
      exp_fd = (k > 0) && (k % 48 == 0);
      total_cnt++;
      if ({drains_a, tetrade_a, dot_a, fdone_a} !== {exp_dr, exp_t, dp_v[slot], exp_fd})
        $display("FAIL scan k=%0d: got %h required %h", k, {drains_a, tetrade_a, dot_a, fdone_a},
                 {exp_dr, exp_t, dp_v[slot], exp_fd});
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_load();
    logic [3:0] exp_t;
    logic       exp_rdy, exp_fd;
    load_data = 32'h1111_1111; load_dp = 8'h00; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    total_cnt++;
    if (ready_a !== 1'b0) $display("FAIL frame_load accept: ready=%b required 0", ready_a);
    else pass_cnt++;
    wait_frame();
    total_cnt++;
    if ({tetrade_a, ready_a} !== {4'h1, 1'b0})
      $display("FAIL frame_load swap: got %h required %h", {tetrade_a, ready_a}, {4'h1, 1'b0});
    else pass_cnt++;
    step();
    total_cnt++;
    if (ready_a !== 1'b1) $display("FAIL frame_load ready_rise: ready=%b required 1", ready_a);
    else pass_cnt++;
    for (int r = 2; r <= 18; r++) step();
    total_cnt++;
    if (drains_a !== 8'h08) $display("FAIL frame_load digit3: drains=%h required 08", drains_a);
    else pass_cnt++;
    load_data = 32'hAAAA_AAAA; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int r = 19; r < 96; r++) begin
      exp_t   = (r < 48) ? 4'h1 : 4'hA;
      exp_rdy = (r >= 49);
      exp_fd  = (r == 48);
      total_cnt++;
      if ({tetrade_a, ready_a, fdone_a} !== {exp_t, exp_rdy, exp_fd})
        $display("FAIL frame_load r=%0d: got %h required %h", r, {tetrade_a, ready_a, fdone_a},
                 {exp_t, exp_rdy, exp_fd});
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    load_data = 32'h1234_5678; load_dp = 8'h01; load_valid = 1'b1;
    step();
    total_cnt++;
    if (ready_a !== 1'b0) $display("FAIL b2b first_accept: ready=%b required 0", ready_a);
    else pass_cnt++;
    load_data = 32'h9ABC_DEF0; load_dp = 8'h02;
    wait_frame();
    total_cnt++;
    if ({tetrade_a, dot_a, ready_a} !== {4'h8, 1'b1, 1'b0})
      $display("FAIL b2b first_word: got %h required %h", {tetrade_a, dot_a, ready_a}, {4'h8, 1'b1, 1'b0});
    else pass_cnt++;
    step();
    total_cnt++;
    if (ready_a !== 1'b1) $display("FAIL b2b ready_rise: ready=%b required 1", ready_a);
    else pass_cnt++;
    step();
    load_valid = 1'b0;
    total_cnt++;
    if (ready_a !== 1'b0) $display("FAIL b2b second_accept: ready=%b required 0", ready_a);
    else pass_cnt++;
    wait_frame();
    total_cnt++;
    if ({tetrade_a, dot_a} !== {4'h0, 1'b0})
      $display("FAIL b2b second_word: got %h required %h", {tetrade_a, dot_a}, {4'h0, 1'b0});
    else pass_cnt++;
  endtask

  task automatic test_en_drop();
    wait_frame();
    for (int r = 1; r <= 30; r++) step();
    total_cnt++;
    if ({drains_a, tetrade_a} !== {8'h20, 4'hB})
      $display("FAIL en_drop digit5: got %h required %h", {drains_a, tetrade_a}, {8'h20, 4'hB});
    else pass_cnt++;
    EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({drains_a, fdone_a} !== {8'h00, 1'b0})
        $display("FAIL en_drop dark c%0d: got %h required %h", i, {drains_a, fdone_a}, {8'h00, 1'b0});
      else pass_cnt++;
    end
    EN = 1'b1;
    step();
    total_cnt++;
    if ({drains_a, tetrade_a} !== {8'h01, 4'h0})
      $display("FAIL en_restart digit0: got %h required %h", {drains_a, tetrade_a}, {8'h01, 4'h0});
    else pass_cnt++;
    for (int i = 0; i < 6; i++) step();
    total_cnt++;
    if ({drains_a, tetrade_a} !== {8'h02, 4'hF})
      $display("FAIL en_restart digit1: got %h required %h", {drains_a, tetrade_a}, {8'h02, 4'hF});
    else pass_cnt++;
    EN = 1'b0;
    step(); step();
  endtask

  task automatic test_mask_blank0();
    logic [7:0] m;
    logic [7:0] exp_dr;
    int slot;
    mask_b = 8'h05; en_b = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      slot   = (k / 4) % 8;
      m      = (k > 32) ? 8'h03 : 8'h05;
      exp_dr = m[slot] ? (8'd1 << slot) : 8'd0;
      total_cnt++;
      if ({drains_b, fdone_b} !== {exp_dr, (k == 32)})
        $display("FAIL mask_b0 k=%0d: got %h required %h", k, {drains_b, fdone_b}, {exp_dr, (k == 32)});
      else pass_cnt++;
      if (k == 32) mask_b = 8'h03;
    end
    en_b = 1'b0;
    step();
  endtask

  task automatic test_lz();
    int top_a, top_b, slot, pos;
    logic [7:0] exp_dr;
`ifdef DISP_LZ_SUPPRESS_EN
    top_a = 2; top_b = 0;
`else
    top_a = 7; top_b = 7;
`endif
    load_data = 32'h0000_0A05; load_dp = 8'h00; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step(); step();
    EN = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step();
      slot = k / 6;
      pos  = k % 6;
      exp_dr = (pos < 4 && slot <= top_a) ? (8'd1 << slot) : 8'd0;
      total_cnt++;
      if (drains_a !== exp_dr) $display("FAIL lz_a05 k=%0d: drains=%h required %h", k, drains_a, exp_dr);
      else pass_cnt++;
    end
    load_data = 32'h0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    wait_frame();
    for (int r = 0; r < 48; r++) begin
      slot = r / 6;
      pos  = r % 6;
      exp_dr = (pos < 4 && slot <= top_b) ? (8'd1 << slot) : 8'd0;
      total_cnt++;
      if ({drains_a, tetrade_a} !== {exp_dr, 4'h0})
        $display("FAIL lz_zero r=%0d: got %h required %h", r, {drains_a, tetrade_a}, {exp_dr, 4'h0});
      else pass_cnt++;
      step();
    end
    EN = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_idle();
    test_scan();
    test_frame_load();
    test_back_to_back();
    test_en_drop();
    test_mask_blank0();
    test_lz();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/disp_scan_sched.md
Name: disp_scan_sched

Overview:
- Scan scheduler for the 8-digit multiplexed 7-segment display.
- Owns digit sequencing: per-digit dwell time, inter-digit blanking (anti-ghosting), double-buffered 32-bit display word with a valid/ready load port, and a per-digit enable mask.
- Drives the digit drains and feeds tetrade/dot to the existing decode_8seg instance.
- Sits between the CPU/SFR-side display register writer and the 7-segment pins.

Parameters:
- DWELL, 1024, CLK cycles each digit is lit (must be >= 1).
- BLANK, 16, CLK cycles all drains are off between digits (0 = no blanking gap).
- CNT_W, 16, width of the dwell/blank counter (must hold max(DWELL, BLANK) - 1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  scan enable; low = display dark, scan parked.
- load_valid  input  1  writer presents new display word.
- load_ready  output  1  shadow buffer free; load accepted when load_valid & load_ready.
- load_data  input  32  8 nibbles; nibble i is bits [4i+3:4i], digit i.
- load_dp  input  8  decimal point per digit, bit i = digit i.
- digit_mask  input  8  bit i = 1 enables digit i; sampled live, not buffered.
- drains  output  8  one-hot digit drain select, 0 = all off.
- tetrade  output  4  nibble for decoder.
- dot  output  1  decimal point for decoder.
- frame_done  output  1  one-cycle pulse at end of digit 7 slot.

Behaviour:
- Reset values (async, RST_N low):
  - drains = 0, tetrade = 0, dot = 0, frame_done = 0, load_ready = 1.
  - Digit index = 0, counter = 0, state = IDLE.
  - Active and shadow buffers = 0, pending = 0.
- All outputs are registered.
- States: IDLE, SHOW, GAP.
  - IDLE:
    - drains = 0.
    - If EN = 1: next state is SHOW with idx = 0 and counter = DWELL - 1.
    - First drains value appears the cycle after EN is sampled high.
  - SHOW:
    - drains = (1 << idx) if digit_mask[idx], else 0.
    - tetrade = active[4*idx +: 4], dot = active_dp[idx].
    - Counter decrements each cycle.
    - At counter = 0: go to GAP with counter = BLANK - 1. If BLANK = 0, skip GAP and go straight to the next digit's SHOW.
  - GAP:
    - drains = 0; tetrade and dot are held.
    - At counter = 0: idx = idx + 1 (wraps 7 -> 0), state = SHOW, counter = DWELL - 1.
- Frame boundary:
  - Defined as leaving digit 7's slot (end of GAP, or end of SHOW when BLANK = 0).
  - frame_done is high for exactly that one cycle.
- Load handshake:
  - On load_valid & load_ready: load_data/load_dp are captured into the shadow buffer and pending is set.
  - load_ready = !pending (registered); it drops the cycle after the accept.
  - load_valid with load_ready = 0 is ignored; the writer must hold it.
- Buffer swap:
  - Shadow is copied to active at the frame boundary if pending, or on any cycle in IDLE if pending.
  - pending clears the same cycle; load_ready rises the next cycle.
  - Digits never display a mix of old and new words within a frame.
- Simultaneous accept and swap: impossible by construction, since pending blocks the accept.
- EN deasserted mid-scan:
  - Next cycle: state = IDLE, drains = 0, idx = 0, counter = 0.
  - Active and shadow contents and pending are retained.
  - The load port remains operational while EN = 0.
- digit_mask change takes effect on the next SHOW-cycle output update, with no buffering.

Optional Feature:
- Macro: DISP_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression.
  - Digit i is forced dark (drains = 0 during its SHOW) when i > the index of the highest nonzero nibble of active.
  - Digit 0 is always shown.
  - Computed from the active buffer at swap time; timing is unchanged.
- Undefined: only digit_mask gates the drains.

Test Plan:
- Reset, then EN = 1, DWELL = 4, BLANK = 2, mask = 8'hFF, load 32'h76543210 while EN = 0:
  - load_ready falls, then rises 2 cycles later (IDLE swap).
  - After EN: drains = 01 for 4 cycles, 00 for 2 cycles, 02 with tetrade = 1, ..., 80 with tetrade = 7.
  - frame_done pulses once per 48 cycles.
- Load 32'hAAAAAAAA during digit 3 of a frame showing 32'h11111111:
  - Remaining digits show 1 until the wrap; all digits show A from the next frame.
  - load_ready stays low until the swap.
- Second load_valid held while pending: not accepted until load_ready = 1, then accepted in the first ready cycle.
- mask = 8'b0000_0101, BLANK = 0: drains sequence 01, 00, 04, 00 x5, each segment DWELL cycles long, with no GAP cycles.
- EN dropped during digit 5 SHOW: drains = 0 the next cycle. Re-enable: restarts at digit 0 with the same active word.
- With DISP_LZ_SUPPRESS_EN, word 32'h00000A05: digits 0–2 lit, digits 3–7 dark. Word 0: only digit 0 lit, showing 0.
